cvp14_mem_seq: RTL and testbench

CVP14_MEM_SEQ -- requirements
Module: cvp14_mem_seq

---
 rtl/cvp14_mem_seq_if.sv | 42 ++++
 rtl/cvp14_mem_seq.sv | 152 +++++++++++++++
 tb/tb_cvp14_mem_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cvp14_mem_seq_if.sv
// Bundle of fetch, vector-op, register-file and memory-port signals for cvp14_mem_seq.
// The sequencer connects through the slave modport; its environment uses master.
interface cvp14_mem_seq_if #(
    parameter int VLEN = 16,
    parameter int AW   = 16
);
    logic                 fetch_req;
    logic [AW-1:0]        fetch_addr;
    logic                 fetch_grant;
    logic                 instr_valid;
    logic [15:0]          instr;

    logic                 op_start;
    logic                 op_store;
    logic [AW-1:0]        op_base;
    logic [2:0]           op_vreg;
    logic [VLEN*16-1:0]   st_data;
    logic                 op_busy;
    logic                 op_done;

    logic                 vrf_wr_en;
    logic [2:0]           vrf_wr_dst;
    logic [VLEN*16-1:0]   vrf_wr_data;

    logic [AW-1:0]        mem_addr;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [15:0]          mem_wdata;
    logic [15:0]          mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, op_start, op_store, op_base, op_vreg, st_data, mem_rdata,
        output fetch_grant, instr_valid, instr, op_busy, op_done,
               vrf_wr_en, vrf_wr_dst, vrf_wr_data, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, op_start, op_store, op_base, op_vreg, st_data, mem_rdata,
        input  fetch_grant, instr_valid, instr, op_busy, op_done,
               vrf_wr_en, vrf_wr_dst, vrf_wr_data, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/cvp14_mem_seq.sv
// Single-port memory sequencer: instruction fetches plus element-serial vector load/store.
// Memory read data returns one cycle after mem_rd, so loads finish with a one-cycle drain.
module cvp14_mem_seq #(
    parameter int VLEN = 16,
    parameter int AW   = 16
) (
    input  logic            Clk1,
    input  logic            Reset,
    cvp14_mem_seq_if.slave  bus
);
    localparam int            CW   = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int            VW   = VLEN * 16;
    localparam logic [CW-1:0] LAST = CW'(VLEN - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, FWAIT, LOAD, DRAIN, WB, STORE, DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  base_q;
    logic [2:0]     vreg_q;
    logic [VW-1:0]  st_q;
    logic [VW-1:0]  vec_q;

    logic           mem_rd_q;
    logic           mem_wr_q;
    logic [AW-1:0]  mem_addr_q;
    logic [15:0]    mem_wdata_q;
    logic           instr_valid_q;
    logic           op_done_q;
    logic           vrf_wr_en_q;

    logic [CW-1:0]  cnt_nxt;
    logic [CW-1:0]  cnt_prev;
    logic [AW-1:0]  addr_nxt;

    assign cnt_nxt  = cnt + 1'b1;
    assign cnt_prev = cnt - 1'b1;
    assign addr_nxt = base_q + AW'(cnt_nxt);

    // Grant is the only combinational handshake; an op in the same cycle wins.
    assign bus.fetch_grant = (state == IDLE) && bus.fetch_req && !bus.op_start && !Reset;

    assign bus.op_busy     = (state != IDLE);
    assign bus.op_done     = op_done_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_valid_q ? bus.mem_rdata : 16'h0000;
    assign bus.vrf_wr_en   = vrf_wr_en_q;
    assign bus.vrf_wr_dst  = vrf_wr_en_q ? vreg_q : 3'd0;
    assign bus.vrf_wr_data = vrf_wr_en_q ? vec_q : '0;

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            base_q        <= '0;
            vreg_q        <= '0;
            st_q          <= '0;
            vec_q         <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            instr_valid_q <= 1'b0;
            op_done_q     <= 1'b0;
            vrf_wr_en_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_start) begin
                        base_q     <= bus.op_base;
                        vreg_q     <= bus.op_vreg;
                        cnt        <= '0;
                        mem_addr_q <= bus.op_base;
                        if (bus.op_store) begin
                            st_q        <= bus.st_data;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= bus.st_data[15:0];
                            state       <= STORE;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state    <= LOAD;
                        end
                    end else if (bus.fetch_req) begin
                        // mem_addr_q doubles as the latched fetch address
                        mem_addr_q <= bus.fetch_addr;
                        mem_rd_q   <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    mem_rd_q      <= 1'b0;
                    mem_addr_q    <= '0;
                    instr_valid_q <= 1'b1;
                    state         <= FWAIT;
                end
                FWAIT: begin
                    instr_valid_q <= 1'b0;
                    state         <= IDLE;
                end
                LOAD: begin
                    // Data arriving now belongs to the previous cycle's read.
                    if (cnt != '0) begin
                        vec_q[{cnt_prev, 4'b0000} +: 16] <= bus.mem_rdata;
                    end
                    if (cnt == LAST) begin
                        mem_rd_q   <= 1'b0;
                        mem_addr_q <= '0;
                        state      <= DRAIN;
                    end else begin
                        cnt        <= cnt_nxt;
                        mem_addr_q <= addr_nxt;
                    end
                end
                DRAIN: begin
                    vec_q[VW-16 +: 16] <= bus.mem_rdata;
                    vrf_wr_en_q        <= 1'b1;
                    op_done_q          <= 1'b1;
                    state              <= WB;
                end
                WB: begin
                    vrf_wr_en_q <= 1'b0;
                    op_done_q   <= 1'b0;
                    state       <= IDLE;
                end
                STORE: begin
                    if (cnt == LAST) begin
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        op_done_q   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt         <= cnt_nxt;
                        mem_addr_q  <= addr_nxt;
                        mem_wdata_q <= st_q[{cnt_nxt, 4'b0000} +: 16];
                    end
                end
                DONE: begin
                    op_done_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cvp14_mem_seq.sv
// Self-checking bench for cvp14_mem_seq: directed table, contention/reset sequences,
// and random ops checked against a word-array memory model.
module tb_cvp14_mem_seq;
    localparam int VLEN = 16;
    localparam int LAT_F = 2;
    localparam int LAT_L = VLEN + 2;
    localparam int LAT_S = VLEN + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cvp14_mem_seq_if #(.VLEN(VLEN), .AW(16)) bus ();
    cvp14_mem_seq #(.VLEN(VLEN), .AW(16)) dut (.Clk1(clk), .Reset(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Environment memory: unwritten words come from init_word.
    logic [15:0] mem     [0:65535];
    bit          wr_mask [0:65535];
    logic [15:0] ref_mem [0:65535];

    function automatic logic [15:0] init_word(logic [15:0] a);
        if (a == 16'h0040) return 16'h2123;
        if (a >= 16'h0100 && a <= 16'h010F) return a - 16'h00FF;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd)
            bus.mem_rdata <= wr_mask[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
        if (bus.mem_wr) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            wr_mask[bus.mem_addr] <= 1'b1;
        end
    end

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] st();
        return {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.op_busy, bus.op_done,
                bus.vrf_wr_en, bus.fetch_grant, bus.instr_valid};
    endfunction

    function automatic logic [22:0] mk(bit rd, bit wr, logic [15:0] a, bit busy, bit done,
                                       bit wen, bit grant, bit iv);
        return {rd, wr, a, busy, done, wen, grant, iv};
    endfunction

    task automatic fetch_tail(logic [15:0] addr, logic [15:0] exp_word, string tag);
        @(negedge clk); bus.fetch_req = 1'b0; #1;
        chk({tag, "_frd"}, st(), mk(1, 0, addr, 1, 0, 0, 0, 0));
        @(negedge clk); #1;
        chk({tag, "_fval"}, st(), mk(0, 0, 16'h0, 1, 0, 0, 0, 1));
        chk({tag, "_instr"}, bus.instr, exp_word);
        chk({tag, "_instr_ref"}, bus.instr, ref_mem[addr]);
        @(negedge clk); #1;
        chk({tag, "_fidle"}, {st(), bus.instr}, {mk(0, 0, 16'h0, 0, 0, 0, 0, 0), 16'h0});
    endtask

    task automatic run_fetch(logic [15:0] addr, logic [15:0] exp_word, string tag);
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = addr; bus.op_start = 1'b0; #1;
        chk({tag, "_grant"}, st(), mk(0, 0, 16'h0, 0, 0, 0, 1, 0));
        fetch_tail(addr, exp_word, tag);
    endtask

    task automatic run_vld(logic [15:0] base, logic [2:0] vreg, bit mid, bit hold, int lat,
                           logic [15:0] exp_word, string tag);
        logic [255:0] expv;
        logic [15:0]  a;
        int           n;
        n = lat - 2;
        for (int i = 0; i < VLEN; i++) begin
            a = base + 16'(i);
            expv[i*16 +: 16] = ref_mem[a];
        end
        @(negedge clk);
        bus.op_start = 1'b1; bus.op_store = 1'b0; bus.op_base = base; bus.op_vreg = vreg;
        bus.fetch_req = hold; #1;
        chk({tag, "_c0"}, st(), mk(0, 0, 16'h0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (mid && k == 5) begin
                bus.op_start = 1'b1; bus.op_store = 1'b1; bus.op_base = ~base;
                bus.op_vreg = ~vreg; bus.fetch_req = 1'b1;
            end else begin
                bus.op_start = 1'b0; bus.op_store = 1'b0; bus.fetch_req = hold;
            end
            #1;
            if (k <= n) begin
                a = base + 16'(k - 1);
                chk($sformatf("%s_rd%0d", tag, k), st(), mk(1, 0, a, 1, 0, 0, 0, 0));
            end else if (k == n + 1) begin
                chk({tag, "_drain"}, st(), mk(0, 0, 16'h0, 1, 0, 0, 0, 0));
            end else if (k == lat) begin
                chk({tag, "_wb"}, st(), mk(0, 0, 16'h0, 1, 1, 1, 0, 0));
                chk({tag, "_dst"}, bus.vrf_wr_dst, vreg);
                chk({tag, "_data"}, bus.vrf_wr_data, expv);
                chk({tag, "_elem0"}, bus.vrf_wr_data[15:0], exp_word);
            end else begin
                chk({tag, "_end"}, st(), mk(0, 0, 16'h0, 0, 0, 0, hold, 0));
                chk({tag, "_end_data"}, {bus.vrf_wr_data, bus.vrf_wr_dst}, '0);
            end
        end
    endtask

    task automatic run_vst(logic [15:0] base, logic [255:0] data, bit mid, bit hold, int lat,
                           logic [15:0] exp_word, string tag);
        logic [15:0] a;
        int          n;
        n = lat - 1;
        @(negedge clk);
        bus.op_start = 1'b1; bus.op_store = 1'b1; bus.op_base = base; bus.st_data = data;
        bus.fetch_req = hold; #1;
        chk({tag, "_c0"}, st(), mk(0, 0, 16'h0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            bus.st_data = {8{$urandom}};
            if (mid && k == 5) begin
                bus.op_start = 1'b1; bus.op_store = 1'b0; bus.op_base = ~base; bus.fetch_req = 1'b1;
            end else begin
                bus.op_start = 1'b0; bus.fetch_req = hold;
            end
            #1;
            if (k <= n) begin
                a = base + 16'(k - 1);
                chk($sformatf("%s_wr%0d", tag, k), st(), mk(0, 1, a, 1, 0, 0, 0, 0));
                chk($sformatf("%s_wd%0d", tag, k), bus.mem_wdata, data[(k-1)*16 +: 16]);
                if (k == 1) chk({tag, "_first"}, bus.mem_wdata, exp_word);
            end else if (k == lat) begin
                chk({tag, "_done"}, st(), mk(0, 0, 16'h0, 1, 1, 0, 0, 0));
                chk({tag, "_done_wd"}, bus.mem_wdata, 16'h0);
            end else begin
                chk({tag, "_end"}, st(), mk(0, 0, 16'h0, 0, 0, 0, hold, 0));
            end
        end
        for (int i = 0; i < VLEN; i++) begin
            a = base + 16'(i);
            ref_mem[a] = data[i*16 +: 16];
        end
    endtask

    function automatic logic [255:0] ramp(logic [15:0] start);
        logic [255:0] d;
        for (int i = 0; i < VLEN; i++) d[i*16 +: 16] = start + 16'(i);
        return d;
    endfunction

    typedef struct {
        int          kind;      // 0 fetch, 1 VLD, 2 VST
        logic [15:0] addr;
        logic [2:0]  vreg;
        logic [15:0] sbase;
        bit          mid;
        int          lat;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [255:0] d;
        logic [15:0]  b;
        int           kind;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(16'(i));

        tbl[0] = '{0, 16'h0040, 3'd0, 16'h0000, 1'b0, LAT_F, 16'h2123};
        tbl[1] = '{1, 16'h0100, 3'd5, 16'h0000, 1'b0, LAT_L, 16'h0001};
        tbl[2] = '{2, 16'hFFF8, 3'd0, 16'hA000, 1'b0, LAT_S, 16'hA000};
        tbl[3] = '{1, 16'hFFF8, 3'd3, 16'h0000, 1'b0, LAT_L, 16'hA000};
        tbl[4] = '{0, 16'hFFFF, 3'd0, 16'h0000, 1'b0, LAT_F, 16'hA007};
        tbl[5] = '{1, 16'h0100, 3'd7, 16'h0000, 1'b1, LAT_L, 16'h0001};
        tbl[6] = '{2, 16'h0200, 3'd0, 16'hB000, 1'b1, LAT_S, 16'hB000};

        rst = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = 16'h0; bus.op_start = 1'b0; bus.op_store = 1'b0;
        bus.op_base = 16'h0; bus.op_vreg = 3'd0; bus.st_data = '0;

        @(negedge clk);
        bus.fetch_req = 1'b1; bus.op_start = 1'b1; bus.fetch_addr = 16'h0040; #1;
        chk("rst_grant", bus.fetch_grant, 1'b0);
        @(negedge clk);
        bus.fetch_req = 1'b0; bus.op_start = 1'b0; #1;
        chk("rst_status", st(), 23'h0);
        chk("rst_outs", {bus.instr, bus.vrf_wr_dst, bus.mem_wdata, bus.vrf_wr_data[63:0]}, '0);
        @(negedge clk); rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            case (tbl[t].kind)
                0: run_fetch(tbl[t].addr, tbl[t].exp_word, $sformatf("tbl%0d", t));
                1: run_vld(tbl[t].addr, tbl[t].vreg, tbl[t].mid, 1'b0, tbl[t].lat,
                           tbl[t].exp_word, $sformatf("tbl%0d", t));
                default: run_vst(tbl[t].addr, ramp(tbl[t].sbase), tbl[t].mid, 1'b0, tbl[t].lat,
                                 tbl[t].exp_word, $sformatf("tbl%0d", t));
            endcase
        end

        // Op and fetch requested together: op first, fetch granted right after.
        bus.fetch_addr = 16'h0040;
        run_vst(16'h0300, ramp(16'hC000), 1'b1, 1'b1, LAT_S, 16'hC000, "cont_vst");
        fetch_tail(16'h0040, 16'h2123, "cont_vst_f");
        bus.fetch_addr = 16'h0300;
        run_vld(16'h0100, 3'd2, 1'b0, 1'b1, LAT_L, 16'h0001, "cont_vld");
        fetch_tail(16'h0300, 16'hC000, "cont_vld_f");

        // Reset in cycle 8 of a load, with op_start and fetch_req also raised.
        @(negedge clk);
        bus.op_start = 1'b1; bus.op_store = 1'b0; bus.op_base = 16'h0500; bus.op_vreg = 3'd6; #1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); bus.op_start = 1'b0; #1;
            chk($sformatf("rstmid_rd%0d", k), st(), mk(1, 0, 16'h0500 + 16'(k - 1), 1, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b1; bus.op_start = 1'b1; bus.op_store = 1'b1; bus.fetch_req = 1'b1; #1;
        chk("rstmid_c8", st(), mk(1, 0, 16'h0507, 1, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0; bus.op_start = 1'b0; bus.fetch_req = 1'b0; #1;
        chk("rstmid_c9", st(), 23'h0);
        chk("rstmid_c9_outs", {bus.instr, bus.vrf_wr_dst, bus.mem_wdata, bus.vrf_wr_data[63:0]}, '0);
        for (int k = 10; k <= 24; k++) begin
            @(negedge clk); #1;
            chk($sformatf("rstmid_quiet%0d", k), st(), 23'h0);
        end
        run_fetch(16'h0040, 16'h2123, "post_rst");

        for (int r = 0; r < 24; r++) begin
            kind = int'($urandom_range(0, 2));
            b = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            for (int i = 0; i < VLEN; i++) d[i*16 +: 16] = 16'($urandom);
            case (kind)
                0: run_fetch(b, ref_mem[b], $sformatf("rnd%0d", r));
                1: run_vld(b, 3'($urandom), 1'($urandom), 1'b0, LAT_L, ref_mem[b],
                           $sformatf("rnd%0d", r));
                default: run_vst(b, d, 1'($urandom), 1'b0, LAT_S, d[15:0], $sformatf("rnd%0d", r));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
